// File: rtl/jtpang_obj_pkg.sv
// Shared definitions for the object row fetcher: FSM states, the default
// transparent pixel value and the object ROM address layout.
package jtpang_obj_pkg;

   // Width of the object ROM slot address
   localparam int OBJ_AW = 18;

   // Pixel value that produces no line-buffer write
   localparam logic [3:0] TRANSP_DEF = 4'hf;

   // Fetcher sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2,
      ST_DRAW = 2'd3
   } obj_state_t;

   // Object ROM word address: one sprite row = two 32-bit words (halves);
   // the lsb is always zero because the slot is addressed in 16-bit units
   typedef struct packed {
      logic [11:0] code;
      logic [3:0]  vrow;
      logic        half;
      logic        lsb;
   } obj_addr_t;

   // Pack the row/half selection into a ROM slot address
   function automatic logic [OBJ_AW-1:0] obj_addr_f(
      input logic [11:0] code,
      input logic [3:0]  vrow,
      input logic        half
   );
      obj_addr_t a;
      a.code = code;
      a.vrow = vrow;
      a.half = half;
      a.lsb  = 1'b0;
      return a;
   endfunction

endpackage

// File: rtl/jtpang_objfetch_unpack.sv
// Planar to packed pixel extraction: each byte of the ROM word holds one bit
// plane, with pixel 0 in the most significant bit of every byte.
module jtpang_objfetch_unpack
   import jtpang_obj_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [2:0]  i_idx,
   output logic [3:0]  o_pix
);

   logic [2:0] w_bit;

   // Select bit (7-idx) of each plane byte, plane 3 in the top byte
   always_comb begin
      w_bit = 3'd7 - i_idx;
      o_pix = { i_data[{2'd3, w_bit}],
                i_data[{2'd2, w_bit}],
                i_data[{2'd1, w_bit}],
                i_data[{2'd0, w_bit}] };
   end

endmodule

// File: rtl/jtpang_objfetch.sv
// Object row fetcher: reads one 16-pixel sprite row as two 32-bit ROM words
// and writes its opaque pixels into the scanline buffer, one per cycle.
module jtpang_objfetch
   import jtpang_obj_pkg::*;
#(
   parameter logic [3:0] TRANSP = TRANSP_DEF,
   parameter int         XW     = 9
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hs,
   input  logic              draw,
   input  logic [11:0]       code,
   input  logic [3:0]        vrow,
   input  logic [XW-1:0]     xpos,
   input  logic              hflip,
   input  logic [3:0]        pal,
   output logic              busy,
   output logic              obj_cs,
   output logic [OBJ_AW-1:0] obj_addr,
   input  logic [31:0]       obj_data,
   input  logic              obj_ok,
   output logic [XW-1:0]     buf_addr,
   output logic [7:0]        buf_data,
   output logic              buf_we
);

   // Latched request
   logic [11:0]       r_code;
   logic [3:0]        r_vrow;
   logic [XW-1:0]     r_xpos;
   logic              r_hflip;
   logic [3:0]        r_pal;

   // Sequencing state
   obj_state_t        r_state;
   logic              r_second;   // 0: first fetched half, 1: second
   logic [2:0]        r_k;        // DRAW cycle count within a half
   logic [31:0]       r_data;     // latched ROM word

   // Registered outputs
   logic              r_busy;
   logic              r_cs;
   logic [OBJ_AW-1:0] r_addr;
   logic [XW-1:0]     r_buf_addr;
   logic [7:0]        r_buf_data;
   logic              r_buf_we;

   // Datapath helpers
   logic [2:0]        w_idx;
   logic [3:0]        w_col;
   logic [XW-1:0]     w_x;
   logic [3:0]        w_pix;
   logic              w_opaque;

   // Pixel index within the word and screen column across the whole row.
   // With hflip the first fetched half is the right one and is read from
   // its last pixel, so screen columns always run 0..15 left to right.
   always_comb begin
      w_idx    = r_hflip ? (3'd7 - r_k) : r_k;
      w_col    = {r_second, r_k};
      w_x      = r_xpos + {{(XW-4){1'b0}}, w_col};
      w_opaque = (w_pix != TRANSP);
   end

   jtpang_objfetch_unpack u_unpack (
      .i_data (r_data),
      .i_idx  (w_idx),
      .o_pix  (w_pix)
   );

   // Fetch/draw sequencer with registered slot and line-buffer outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_code     <= 12'd0;
         r_vrow     <= 4'd0;
         r_xpos     <= {XW{1'b0}};
         r_hflip    <= 1'b0;
         r_pal      <= 4'd0;
         r_second   <= 1'b0;
         r_k        <= 3'd0;
         r_data     <= 32'd0;
         r_busy     <= 1'b0;
         r_cs       <= 1'b0;
         r_addr     <= {OBJ_AW{1'b0}};
         r_buf_addr <= {XW{1'b0}};
         r_buf_data <= 8'd0;
         r_buf_we   <= 1'b0;
      end else if (hs) begin
         // Line start aborts everything; a simultaneous draw is dropped
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_cs     <= 1'b0;
         r_buf_we <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_buf_we <= 1'b0;
               if (draw) begin
                  r_code   <= code;
                  r_vrow   <= vrow;
                  r_xpos   <= xpos;
                  r_hflip  <= hflip;
                  r_pal    <= pal;
                  r_second <= 1'b0;
                  r_k      <= 3'd0;
                  // first fetched half is the right one when flipped
                  r_addr   <= obj_addr_f(code, vrow, hflip);
                  r_cs     <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= ST_ADDR;
               end else begin
                  r_state  <= ST_IDLE;
               end
            end
            ST_ADDR: begin
               // single cycle so an ok belonging to the old address is skipped
               r_buf_we <= 1'b0;
               r_state  <= ST_WAIT;
            end
            ST_WAIT: begin
               r_buf_we <= 1'b0;
               if (obj_ok) begin
                  r_data  <= obj_data;
                  r_cs    <= 1'b0;
                  r_k     <= 3'd0;
                  r_state <= ST_DRAW;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_DRAW: begin
               r_buf_addr <= w_x;
               r_buf_data <= {r_pal, w_pix};
               r_buf_we   <= w_opaque;
               r_k        <= r_k + 3'd1;
               if (r_k == 3'd7) begin
                  if (!r_second) begin
                     r_second <= 1'b1;
                     r_addr   <= obj_addr_f(r_code, r_vrow, ~r_hflip);
                     r_cs     <= 1'b1;
                     r_state  <= ST_ADDR;
                  end else begin
                     r_busy   <= 1'b0;
                     r_state  <= ST_IDLE;
                  end
               end else begin
                  r_state <= ST_DRAW;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_cs     <= 1'b0;
               r_buf_we <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign obj_cs   = r_cs;
   assign obj_addr = r_addr;
   assign buf_addr = r_buf_addr;
   assign buf_data = r_buf_data;
   assign buf_we   = r_buf_we;

endmodule

// File: tb/tb_jtpang_objfetch.sv
// Randomised scoreboard bench for the object row fetcher.
module tb_jtpang_objfetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hs = 1'b0;
   logic        draw = 1'b0;
   logic [11:0] code = 12'd0;
   logic [3:0]  vrow = 4'd0;
   logic [8:0]  xpos = 9'd0;
   logic        hflip = 1'b0;
   logic [3:0]  pal = 4'd0;
   logic        busy;
   logic        obj_cs;
   logic [17:0] obj_addr;
   logic [31:0] obj_data = 32'd0;
   logic        obj_ok = 1'b0;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_data;
   logic        buf_we;

   jtpang_objfetch dut (
      .clk(clk), .rst_n(rst_n), .hs(hs), .draw(draw), .code(code),
      .vrow(vrow), .xpos(xpos), .hflip(hflip), .pal(pal), .busy(busy),
      .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data),
      .obj_ok(obj_ok), .buf_addr(buf_addr), .buf_data(buf_data),
      .buf_we(buf_we)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct { logic [8:0] addr; logic [7:0] data; } wr_t;
   wr_t         exp_wr[$];
   logic [17:0] exp_fa[$];

   int          n_wr = 0;
   int          n_fetch = 0;
   logic        prev_cs = 1'b0;

   int          rom_cnt = 0;
   int          rom_delay = 0;
   bit          stale_ok = 1'b0;
   logic [31:0] rom_w[2];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: builds expected fetch addresses and buffer writes
   function automatic int push_expect(input logic [11:0] c, input logic [3:0] v,
                                      input logic [8:0] x, input logic hf,
                                      input logic [3:0] p, input logic [31:0] a0,
                                      input logic [31:0] a1, input int ncols);
      int cnt = 0;
      int first = hf ? 1 : 0;
      exp_fa.push_back(18'(c * 64 + v * 4 + first * 2));
      exp_fa.push_back(18'(c * 64 + v * 4 + (1 - first) * 2));
      for (int n = 0; n < ncols; n++) begin
         int s = hf ? 15 - n : n;
         logic [31:0] w = (s < 8) ? a0 : a1;
         int i = s % 8;
         logic [3:0] px;
         wr_t e;
         px = {w[31 - i], w[23 - i], w[15 - i], w[7 - i]};
         if (px != 4'hf) begin
            e.addr = 9'((x + n) % 512);
            e.data = {p, px};
            exp_wr.push_back(e);
            cnt++;
         end
      end
      return cnt;
   endfunction

   // ROM slot model: stale ok around ADDR, real data after rom_delay WAIT cycles
   always @(negedge clk) begin
      if (!obj_cs) begin
         rom_cnt  = 0;
         obj_ok   = stale_ok;
         obj_data = $urandom;
      end else begin
         rom_cnt = rom_cnt + 1;
         if (rom_cnt >= 2 + rom_delay) begin
            obj_ok   = 1'b1;
            obj_data = rom_w[obj_addr[1]];
         end else begin
            obj_ok   = (rom_cnt == 1) ? stale_ok : 1'b0;
            obj_data = $urandom;
         end
      end
   end

   // Monitor: compares fetch addresses and buffer writes against the queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (obj_cs && !prev_cs) begin
            n_fetch++;
            if (exp_fa.size() > 0) begin
               check("fetch_addr", obj_addr, exp_fa.pop_front());
            end else begin
               checks++; errors++;
               $display("FAIL fetch_unexpected: got addr %0h expected none", obj_addr);
            end
         end
         if (buf_we) begin
            wr_t e;
            n_wr++;
            if (exp_wr.size() > 0) begin
               e = exp_wr.pop_front();
               check("buf_addr", buf_addr, e.addr);
               check("buf_data", buf_data, e.data);
            end else begin
               checks++; errors++;
               $display("FAIL wr_unexpected: got addr %0h data %0h expected none", buf_addr, buf_data);
            end
         end
      end
      prev_cs = obj_cs;
   end

   task automatic do_req(input logic [11:0] c, input logic [3:0] v, input logic [8:0] x,
                         input logic hf, input logic [3:0] p, input logic [31:0] a0,
                         input logic [31:0] a1, input int dly, input bit poke);
      int nexp;
      int wr0;
      int n = 0;
      rom_w[0] = a0; rom_w[1] = a1; rom_delay = dly;
      nexp = push_expect(c, v, x, hf, p, a0, a1, 16);
      wr0 = n_wr;
      @(negedge clk);
      code = c; vrow = v; xpos = x; hflip = hf; pal = p; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      while (busy && n < 500) begin
         n++;
         if (poke && n == 4) begin
            draw = 1'b1; code = 12'($urandom); xpos = 9'($urandom); hflip = ~hf;
         end else begin
            draw = 1'b0;
         end
         @(negedge clk);
      end
      draw = 1'b0;
      @(negedge clk);
      check("busy_cycles", n, 20 + 2 * dly);
      check("write_count", n_wr - wr0, nexp);
      check("wr_queue_left", exp_wr.size(), 0);
      check("fa_queue_left", exp_fa.size(), 0);
   endtask

   initial begin
      int n;
      int nx;
      #12;
      check("rst_busy", busy, 0);
      check("rst_cs", obj_cs, 0);
      check("rst_addr", obj_addr, 0);
      check("rst_we", buf_we, 0);
      check("rst_baddr", buf_addr, 0);
      check("rst_bdata", buf_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic draw, transparency, flipped, wrap
      do_req(12'h123, 4'd5, 9'd100, 1'b0, 4'd3, 32'h00FF_00FF, 32'h0000_0000, 0, 1'b0);
      do_req(12'h0A5, 4'd2, 9'd40, 1'b0, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      do_req(12'h123, 4'd5, 9'd0, 1'b1, 4'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
      do_req(12'h3C7, 4'd9, 9'd505, 1'b0, 4'd1, 32'h0000_0000, 32'h0000_0000, 1, 1'b0);

      // stale ok held through ADDR, then a slow ROM
      stale_ok = 1'b1;
      do_req(12'hFED, 4'd15, 9'd300, 1'b1, 4'd9, 32'h0F0F_3C3C, 32'hA5A5_5A5A, 10, 1'b0);
      stale_ok = 1'b0;

      // randomised requests, some with a draw pulse while busy
      for (int r = 0; r < 8; r++) begin
         do_req(12'($urandom), 4'($urandom), 9'($urandom), 1'($urandom), 4'($urandom),
                $urandom, $urandom | 32'h0F00_0000, int'($urandom_range(0, 3)), r[0]);
      end

      // hs and draw together: hs wins
      @(negedge clk);
      hs = 1'b1; draw = 1'b1; code = 12'h111;
      @(negedge clk);
      hs = 1'b0; draw = 1'b0;
      check("hsdraw_busy", busy, 0);
      check("hsdraw_cs", obj_cs, 0);
      repeat (5) @(negedge clk);

      // abort with hs during the second WAIT
      rom_w[0] = 32'h0; rom_w[1] = 32'h0; rom_delay = 5;
      void'(push_expect(12'h456, 4'd3, 9'd200, 1'b0, 4'd4, 32'h0, 32'h0, 8));
      nx = n_fetch;
      @(negedge clk);
      code = 12'h456; vrow = 4'd3; xpos = 9'd200; hflip = 1'b0; pal = 4'd4; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      n = 0;
      while (n_fetch < nx + 2 && n < 200) begin n++; @(negedge clk); end
      check("abort_reached_second", n_fetch - nx, 2);
      repeat (2) @(negedge clk);
      hs = 1'b1;
      @(negedge clk);
      hs = 1'b0;
      check("abort_cs", obj_cs, 0);
      check("abort_busy", busy, 0);
      repeat (15) @(negedge clk);
      check("abort_wr_left", exp_wr.size(), 0);

      // reset asserted in the middle of DRAW
      rom_w[0] = 32'h0; rom_w[1] = 32'h0; rom_delay = 0;
      void'(push_expect(12'h222, 4'd1, 9'd10, 1'b0, 4'd2, 32'h0, 32'h0, 16));
      @(negedge clk);
      code = 12'h222; vrow = 4'd1; xpos = 9'd10; hflip = 1'b0; pal = 4'd2; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_we", buf_we, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_cs", obj_cs, 0);
      check("rstmid_addr", obj_addr, 0);
      check("rstmid_baddr", buf_addr, 0);
      exp_wr.delete();
      exp_fa.delete();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_req(12'h321, 4'd6, 9'd77, 1'b1, 4'd5, 32'hC3C3_1818, 32'h7E7E_FF00, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
